// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the fetch stage:
//   pc_state_e       - fetch FSM states (BOOT / RUN / FLUSH)
//   NOP              - instruction word placed in a squashed IF/ID slot
//   DEFAULT_RESET_PC - default PC loaded while reset is asserted
// ----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pc_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_target_mux.sv
// ----------------------------------------------------------------------------
// pc_target_mux
// Combinational next-PC selection. Priority: Jr > Jump > Branch > sequential.
// Redirect controls arrive already qualified (slot valid, no stall).
// Ports:
//   i_jr, i_jump, i_branch - qualified redirect requests
//   i_jr_tgt               - register-sourced target
//   i_jump_tgt             - 26-bit index already shifted left twice
//   i_branch_off           - sign-extended offset already shifted left twice
//   i_if_id_pc_plus4       - PC+4 of the instruction sitting in ID
//   i_pc_plus4             - sequential fetch address
//   o_next_pc              - selected next PC
//   o_redirect             - any redirect is being taken
//   o_jr_misalign          - (PC_ALIGN_CHK_EN only) Jr target had low bits set
// Optional feature macro: PC_ALIGN_CHK_EN (word-align Jr targets).
// ----------------------------------------------------------------------------
module pc_target_mux (
    input  logic        i_jr,
    input  logic        i_jump,
    input  logic        i_branch,
    input  logic [31:0] i_jr_tgt,
    input  logic [27:0] i_jump_tgt,
    input  logic [31:0] i_branch_off,
    input  logic [31:0] i_if_id_pc_plus4,
    input  logic [31:0] i_pc_plus4,
`ifdef PC_ALIGN_CHK_EN
    output logic        o_jr_misalign,
`endif
    output logic [31:0] o_next_pc,
    output logic        o_redirect
);

    logic [31:0] w_jr_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;

    // Jump keeps the 256 MB region of the instruction in ID, not of the fetch PC.
    assign w_jump_target   = {i_if_id_pc_plus4[31:28], i_jump_tgt};
    assign w_branch_target = i_if_id_pc_plus4 + i_branch_off;

`ifdef PC_ALIGN_CHK_EN
    assign w_jr_target   = {i_jr_tgt[31:2], 2'b00};
    assign o_jr_misalign = i_jr && (i_jr_tgt[1:0] != 2'b00);
`else
    assign w_jr_target   = i_jr_tgt;
`endif

    assign o_redirect = i_jr | i_jump | i_branch;

    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jr) begin
            o_next_pc = w_jr_target;
        end else if (i_jump) begin
            o_next_pc = w_jump_target;
        end else if (i_branch) begin
            o_next_pc = w_branch_target;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// ----------------------------------------------------------------------------
// next_pc_unit
// Program counter and IF/ID pipeline register with a BOOT/RUN/FLUSH fetch FSM.
// A redirect from ID loads the target on the next edge and squashes the
// wrong-path instruction (one bubble, no delay slot).
// Ports:
//   CLK, RST (sync, active-low)
//   Stall                    - freezes PC, IF/ID and FSM
//   Branch_Taken/Branch_Off  - branch redirect
//   Jump/Jump_Tgt            - J/JAL redirect
//   Jr/Jr_Tgt                - JR redirect
//   Instr_In                 - instruction memory read data for PC
//   PC                       - instruction memory address
//   IF_ID_PC_Plus4, IF_ID_Instr, IF_ID_Valid - IF/ID register outputs
//   Misalign                 - (PC_ALIGN_CHK_EN only) one-cycle pulse when a
//                              Jr target was force-aligned
// Optional feature macro: PC_ALIGN_CHK_EN.
// ----------------------------------------------------------------------------
module next_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Off,
    input  logic        Jump,
    input  logic [27:0] Jump_Tgt,
    input  logic        Jr,
    input  logic [31:0] Jr_Tgt,
    input  logic [31:0] Instr_In,
`ifdef PC_ALIGN_CHK_EN
    output logic        Misalign,
`endif
    output logic [31:0] PC,
    output logic [31:0] IF_ID_PC_Plus4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid
);

    pc_state_e   r_state;
    pc_state_e   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc_plus4;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic [31:0] w_pc_next;
    logic [31:0] w_if_id_pc_plus4_next;
    logic [31:0] w_if_id_instr_next;
    logic        w_if_id_valid_next;

    logic [31:0] w_pc_plus4;
    logic        w_redirect_ok;
    logic [31:0] w_target_pc;
    logic        w_redirect;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Redirects only come from a real instruction in ID, and never during a stall.
    assign w_redirect_ok = r_if_id_valid & ~Stall;

`ifdef PC_ALIGN_CHK_EN
    logic r_misalign;
    logic w_misalign_next;
    logic w_jr_misalign;
`endif

    pc_target_mux u_mux (
        .i_jr             (Jr & w_redirect_ok),
        .i_jump           (Jump & w_redirect_ok),
        .i_branch         (Branch_Taken & w_redirect_ok),
        .i_jr_tgt         (Jr_Tgt),
        .i_jump_tgt       (Jump_Tgt),
        .i_branch_off     (Branch_Off),
        .i_if_id_pc_plus4 (r_if_id_pc_plus4),
        .i_pc_plus4       (w_pc_plus4),
`ifdef PC_ALIGN_CHK_EN
        .o_jr_misalign    (w_jr_misalign),
`endif
        .o_next_pc        (w_target_pc),
        .o_redirect       (w_redirect)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        if (!Stall) begin
            case (r_state)
                BOOT:    w_state_next = RUN;
                RUN:     w_state_next = w_redirect ? FLUSH : RUN;
                FLUSH:   w_state_next = RUN;
                default: w_state_next = BOOT;
            endcase
        end
    end

    // FSM outputs: next values of PC and IF/ID. Every state fetches; only RUN
    // can hold a valid slot, so only RUN can redirect.
    always_comb begin
        w_pc_next             = r_pc;
        w_if_id_pc_plus4_next = r_if_id_pc_plus4;
        w_if_id_instr_next    = r_if_id_instr;
        w_if_id_valid_next    = r_if_id_valid;
`ifdef PC_ALIGN_CHK_EN
        w_misalign_next       = 1'b0;
`endif
        if (!Stall) begin
            if ((r_state == RUN) && w_redirect) begin
                w_pc_next          = w_target_pc;
                w_if_id_instr_next = NOP;
                w_if_id_valid_next = 1'b0;
`ifdef PC_ALIGN_CHK_EN
                w_misalign_next    = w_jr_misalign;
`endif
            end else begin
                w_pc_next             = w_pc_plus4;
                w_if_id_pc_plus4_next = w_pc_plus4;
                w_if_id_instr_next    = Instr_In;
                w_if_id_valid_next    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_pc             <= RESET_PC;
            r_if_id_pc_plus4 <= 32'h0;
            r_if_id_instr    <= NOP;
            r_if_id_valid    <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
            r_misalign       <= 1'b0;
`endif
        end else begin
            r_pc             <= w_pc_next;
            r_if_id_pc_plus4 <= w_if_id_pc_plus4_next;
            r_if_id_instr    <= w_if_id_instr_next;
            r_if_id_valid    <= w_if_id_valid_next;
`ifdef PC_ALIGN_CHK_EN
            r_misalign       <= w_misalign_next;
`endif
        end
    end

    assign PC             = r_pc;
    assign IF_ID_PC_Plus4 = r_if_id_pc_plus4;
    assign IF_ID_Instr    = r_if_id_instr;
    assign IF_ID_Valid    = r_if_id_valid;
`ifdef PC_ALIGN_CHK_EN
    assign Misalign       = r_misalign;
`endif

endmodule
